// File: rtl/seletor_bcd_seq_if.sv
// Bus for seletor_bcd_seq: Start command, operation code, operands, and the
// status/digit outputs. Master drives the command side, slave is the selector.
// Widths follow the operand/result digit parameters of the selector instance.
interface seletor_bcd_seq_if #(
  parameter int OPW  = 7,
  parameter int ODIG = 2,
  parameter int RDIG = 4
);
  logic                i_start;
  logic [2:0]          i_estado;
  logic [OPW-1:0]      i_n1;
  logic [OPW-1:0]      i_n2;
  logic                o_busy;
  logic                o_done;
  logic                o_erro;
  logic [4*ODIG-1:0]   o_n1_dig;
  logic [4*ODIG-1:0]   o_n2_dig;
  logic [4*RDIG-1:0]   o_res_dig;

  modport master (
    output i_start, i_estado, i_n1, i_n2,
    input  o_busy, o_done, o_erro, o_n1_dig, o_n2_dig, o_res_dig
  );

  modport slave (
    input  i_start, i_estado, i_n1, i_n2,
    output o_busy, o_done, o_erro, o_n1_dig, o_n2_dig, o_res_dig
  );
endinterface

// File: rtl/seletor_bcd_seq.sv
// Sequential calculator selector: clamps operands, shows them as BCD digits,
// and on Start computes Soma/Sub/Mult/Div, converting the result to blanked,
// signed BCD digit codes (10 = minus, 11 = blank) via shift-add-3.
module seletor_bcd_seq #(
  parameter int OPW  = 7,
  parameter int ODIG = 2,
  parameter int RDIG = 4
) (
  input logic              i_clk,
  input logic              i_rst,
  seletor_bcd_seq_if.slave io_bus
);

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam int             RW     = 2 * OPW;
  localparam int             OMAX_I = pow10(ODIG) - 1;
  localparam logic [OPW-1:0] OMAX   = OMAX_I[OPW-1:0];
  localparam logic [31:0]    RLIM   = 32'(pow10(RDIG));
  localparam int             CW     = $clog2(RW + 1);
  localparam int             LW     = $clog2(RDIG + 1);

  localparam logic [2:0] E_OFF  = 3'd0;
  localparam logic [2:0] E_SOMA = 3'd1;
  localparam logic [2:0] E_SUB  = 3'd2;
  localparam logic [2:0] E_MULT = 3'd3;
  localparam logic [2:0] E_DIV  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_CONV, S_DONE} state_t;

  state_t            r_state;
  logic [OPW-1:0]    r_a, r_b, r_q, r_rem;
  logic [2:0]        r_op;
  logic [CW-1:0]     r_cnt;
  logic [RW-1:0]     r_sh;
  logic [4*RDIG-1:0] r_bcd, r_res;
  logic [4*ODIG-1:0] r_n1_dig, r_n2_dig;
  logic              r_neg, r_err, r_blank, r_busy, r_done, r_erro;

  logic [OPW-1:0]    w_n1c, w_n2c;
  logic [OPW:0]      w_rem_sh, w_trial;
  logic [RW-1:0]     w_a_ext, w_b_ext, w_mag;
  logic              w_over, w_valid_op, w_sign_ovf;
  logic [4*RDIG-1:0] w_bcd_adj, w_res_fmt;
  logic [LW-1:0]     w_lead;

  // Combinational double-dabble for the operand display (operands are clamped, so they fit)
  function automatic logic [4*ODIG-1:0] to_bcd(input logic [OPW-1:0] v);
    logic [4*ODIG-1:0] d;
    d = '0;
    for (int i = OPW - 1; i >= 0; i--) begin
      for (int j = 0; j < ODIG; j++)
        if (d[4*j +: 4] >= 4'd5) d[4*j +: 4] = d[4*j +: 4] + 4'd3;
      d = {d[4*ODIG-2:0], v[i]};
    end
    return d;
  endfunction

  assign w_n1c      = (io_bus.i_n1 > OMAX) ? OMAX : io_bus.i_n1;
  assign w_n2c      = (io_bus.i_n2 > OMAX) ? OMAX : io_bus.i_n2;
  assign w_valid_op = (io_bus.i_estado == E_SOMA) || (io_bus.i_estado == E_SUB) ||
                      (io_bus.i_estado == E_MULT) || (io_bus.i_estado == E_DIV);

  // Restoring-division step: shift in the next dividend bit, try subtracting the divisor
  assign w_rem_sh = {r_rem, r_q[OPW-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_b};

  // Result magnitude of the latched operation and its range check against 10^RDIG
  always_comb begin
    w_a_ext = {{OPW{1'b0}}, r_a};
    w_b_ext = {{OPW{1'b0}}, r_b};
    w_mag   = '0;
    case (r_op)
      E_SOMA:  w_mag = w_a_ext + w_b_ext;
      E_SUB:   w_mag = (r_a >= r_b) ? (w_a_ext - w_b_ext) : (w_b_ext - w_a_ext);
      E_MULT:  w_mag = w_a_ext * w_b_ext;
      default: w_mag = {{OPW{1'b0}}, r_q};
    endcase
    w_over = ({{(32-RW){1'b0}}, w_mag} >= RLIM);
  end

  // Add-3 correction applied to every BCD digit before each conversion shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int j = 0; j < RDIG; j++)
      if (r_bcd[4*j +: 4] >= 4'd5) w_bcd_adj[4*j +: 4] = r_bcd[4*j +: 4] + 4'd3;
  end

  // Leading-zero blanking and minus-sign placement on the converted digits
  always_comb begin
    w_lead    = '0;
    w_res_fmt = '1;
    for (int i = 0; i < RDIG; i++)
      if (r_bcd[4*i +: 4] != 4'd0) w_lead = LW'(i);
    w_sign_ovf = r_neg && (w_lead == LW'(RDIG - 1));
    for (int i = 0; i < RDIG; i++) begin
      if (LW'(i) <= w_lead)                         w_res_fmt[4*i +: 4] = r_bcd[4*i +: 4];
      else if (r_neg && (LW'(i) == w_lead + 1'b1)) w_res_fmt[4*i +: 4] = 4'd10;
      else                                         w_res_fmt[4*i +: 4] = 4'd11;
    end
  end

  // Operand display: free-running, one cycle behind the inputs, blanked when Off
  always_ff @(posedge i_clk) begin
    if (i_rst || (io_bus.i_estado == E_OFF)) begin
      r_n1_dig <= {ODIG{4'd11}};
      r_n2_dig <= {ODIG{4'd11}};
    end else begin
      r_n1_dig <= to_bcd(w_n1c);
      r_n2_dig <= to_bcd(w_n2c);
    end
  end

  // Command FSM: latch, compute (iterative for Div), convert, publish result
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_op    <= E_OFF;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_bcd   <= '0;
      r_neg   <= 1'b0;
      r_err   <= 1'b0;
      r_blank <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_erro  <= 1'b0;
      r_res   <= {RDIG{4'd11}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_bus.i_start) begin
            r_a     <= w_n1c;
            r_b     <= w_n2c;
            r_q     <= w_n1c;
            r_rem   <= '0;
            r_op    <= io_bus.i_estado;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_err   <= 1'b0;
            r_blank <= !w_valid_op;
            r_busy  <= 1'b1;
            r_state <= w_valid_op ? S_CALC : S_DONE;
          end
        end
        S_CALC: begin
          if ((r_op == E_DIV) && (r_cnt != CW'(OPW))) begin
            r_cnt <= r_cnt + 1'b1;
            if (!w_trial[OPW]) begin
              r_rem <= w_trial[OPW-1:0];
              r_q   <= {r_q[OPW-2:0], 1'b1};
            end else begin
              r_rem <= w_rem_sh[OPW-1:0];
              r_q   <= {r_q[OPW-2:0], 1'b0};
            end
          end else begin
            r_neg <= (r_op == E_SUB) && (r_a < r_b);
            r_sh  <= w_mag;
            r_bcd <= '0;
            r_cnt <= '0;
            if (((r_op == E_DIV) && (r_b == '0)) || w_over) begin
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_CONV;
            end
          end
        end
        S_CONV: begin
          {r_bcd, r_sh} <= {w_bcd_adj, r_sh} << 1;
          r_cnt         <= r_cnt + 1'b1;
          if (r_cnt == CW'(RW - 1)) r_state <= S_DONE;
        end
        default: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (r_blank) begin
            r_res  <= {RDIG{4'd11}};
            r_erro <= 1'b0;
          end else if (r_err || w_sign_ovf) begin
            r_res  <= {RDIG{4'd11}};
            r_erro <= 1'b1;
          end else begin
            r_res  <= w_res_fmt;
            r_erro <= 1'b0;
          end
        end
      endcase
    end
  end

  assign io_bus.o_busy    = r_busy;
  assign io_bus.o_done    = r_done;
  assign io_bus.o_erro    = r_erro;
  assign io_bus.o_n1_dig  = r_n1_dig;
  assign io_bus.o_n2_dig  = r_n2_dig;
  assign io_bus.o_res_dig = r_res;

endmodule
